sccb_target: RTL and testbench



---
 rtl/sccb_target_if.sv | 22 ++
 rtl/sccb_target.sv | 193 +++++++++++++++++++
 tb/tb_sccb_target.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_target_if.sv
// SCCB target bus bundle: pad-side SIO_C/SIO_D plus the register-write
// observation and status outputs.
interface sccb_target_if;
    logic       sio_c_i;
    logic       sio_d_i;
    logic       sio_d_oe;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [7:0] sub_addr;

    modport slave (
        input  sio_c_i, sio_d_i,
        output sio_d_oe, wr_strobe, wr_addr, wr_data, busy, sub_addr
    );

    modport master (
        output sio_c_i, sio_d_i,
        input  sio_d_oe, wr_strobe, wr_addr, wr_data, busy, sub_addr
    );
endinterface

// File: rtl/sccb_target.sv
// SCCB/I2C-style camera-side target with a 256x8 register file that mimics an
// OV7670-class sensor; oversamples SIO_C/SIO_D and drives SIO_D open-drain.
module sccb_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h21,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] PID_VALUE   = 8'h76,
    parameter logic [7:0] VER_VALUE   = 8'h73
) (
    input logic          clk,
    input logic          reset,
    sccb_target_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, DEV, ACK_DEV, SUB, ACK_SUB, WDATA, ACK_WDATA, RDATA, RD_NA, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] c_sync_q, d_sync_q;
    logic                   c_prev_q, d_prev_q;
    logic                   c_s, d_s;
    logic                   c_rise, c_fall, start_det, stop_det;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [7:0] sh_q;
    logic       ack_q;
    logic       rw_q;
    logic       oe_q;
    logic       strb_q;
    logic [7:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic       busy_q;
    logic [7:0] sub_addr_q;
    logic [7:0] regs_q [256];
    logic [7:0] rx_byte;
    logic [7:0] rd_byte;

    function automatic logic is_ro(input logic [7:0] a);
        return (a == 8'h0A) || (a == 8'h0B) || (a == 8'h1C) || (a == 8'h1D);
    endfunction

    function automatic logic [7:0] reg_default(input logic [7:0] a);
        case (a)
            8'h0A:   return PID_VALUE;
            8'h0B:   return VER_VALUE;
            8'h1C:   return 8'h7F;
            8'h1D:   return 8'hA2;
            default: return 8'h00;
        endcase
    endfunction

    // Pad synchronizers run freely so the chain is always primed with the
    // live bus level; reset only acts on the protocol state below.
    always_ff @(posedge clk) begin
        c_sync_q <= {c_sync_q[SYNC_STAGES-2:0], bus.sio_c_i};
        d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], bus.sio_d_i};
        c_prev_q <= c_sync_q[SYNC_STAGES-1];
        d_prev_q <= d_sync_q[SYNC_STAGES-1];
    end

    assign c_s       = c_sync_q[SYNC_STAGES-1];
    assign d_s       = d_sync_q[SYNC_STAGES-1];
    assign c_rise    = c_s & ~c_prev_q;
    assign c_fall    = ~c_s & c_prev_q;
    assign start_det = c_s & c_prev_q & d_prev_q & ~d_s;
    assign stop_det  = c_s & c_prev_q & ~d_prev_q & d_s;
    assign rx_byte   = {sh_q[6:0], d_s};
    assign rd_byte   = regs_q[sub_addr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            sh_q       <= 8'h00;
            ack_q      <= 1'b0;
            rw_q       <= 1'b0;
            oe_q       <= 1'b0;
            strb_q     <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            sub_addr_q <= 8'h00;
            for (int i = 0; i < 256; i++) begin
                regs_q[i] <= reg_default(8'(i));
            end
        end else begin
            strb_q <= 1'b0;
            if (start_det) begin
                state_q <= DEV;
                cnt_q   <= 4'd0;
                ack_q   <= 1'b0;
                oe_q    <= 1'b0;
                busy_q  <= 1'b1;
            end else if (stop_det) begin
                state_q <= IDLE;
                ack_q   <= 1'b0;
                oe_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, IGNORE: oe_q <= 1'b0;
                    DEV, SUB, WDATA: begin
                        if (c_rise) begin
                            sh_q  <= rx_byte;
                            cnt_q <= cnt_q + 4'd1;
                            if (cnt_q == 4'd7) begin
                                if (state_q == DEV) begin
                                    rw_q    <= rx_byte[0];
                                    state_q <= (rx_byte[7:1] == DEV_ADDR) ? ACK_DEV : IGNORE;
                                end else if (state_q == SUB) begin
                                    sub_addr_q <= rx_byte;
                                    state_q    <= ACK_SUB;
                                end else begin
                                    if (!is_ro(sub_addr_q)) begin
                                        regs_q[sub_addr_q] <= rx_byte;
                                        strb_q             <= 1'b1;
                                        wr_addr_q          <= sub_addr_q;
                                        wr_data_q          <= rx_byte;
                                    end
                                    sub_addr_q <= sub_addr_q + 8'd1;
                                    state_q    <= ACK_WDATA;
                                end
                            end
                        end
                    end
                    // First c_fall pulls the ACK low, the second ends the ACK slot.
                    ACK_DEV, ACK_SUB, ACK_WDATA: begin
                        if (c_fall) begin
                            if (!ack_q) begin
                                oe_q  <= 1'b1;
                                ack_q <= 1'b1;
                            end else begin
                                ack_q <= 1'b0;
                                cnt_q <= 4'd0;
                                if (state_q == ACK_DEV && rw_q) begin
                                    oe_q    <= ~rd_byte[7];
                                    sh_q    <= {rd_byte[6:0], 1'b0};
                                    cnt_q   <= 4'd1;
                                    state_q <= RDATA;
                                end else begin
                                    oe_q    <= 1'b0;
                                    state_q <= (state_q == ACK_DEV) ? SUB : WDATA;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        if (c_fall) begin
                            if (cnt_q == 4'd8) begin
                                oe_q    <= 1'b0;
                                ack_q   <= 1'b0;
                                state_q <= RD_NA;
                            end else begin
                                oe_q  <= ~sh_q[7];
                                sh_q  <= {sh_q[6:0], 1'b0};
                                cnt_q <= cnt_q + 4'd1;
                            end
                        end
                    end
                    // ack_q marks a master ACK seen; the next byte starts on the following c_fall.
                    RD_NA: begin
                        if (c_rise && !ack_q) begin
                            if (d_s) begin
                                state_q <= IGNORE;
                            end else begin
                                sub_addr_q <= sub_addr_q + 8'd1;
                                ack_q      <= 1'b1;
                            end
                        end else if (c_fall && ack_q) begin
                            ack_q   <= 1'b0;
                            oe_q    <= ~rd_byte[7];
                            sh_q    <= {rd_byte[6:0], 1'b0};
                            cnt_q   <= 4'd1;
                            state_q <= RDATA;
                        end
                    end
                    default: begin
                        oe_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sio_d_oe  = oe_q;
    assign bus.wr_strobe = strb_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = busy_q;
    assign bus.sub_addr  = sub_addr_q;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: acts as SCCB master and checks the target against a
// transaction-level model of the register file, pointer and write events.
module tb_sccb_target;
    localparam int Q = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scl = 1'b1;
    logic sda_m = 1'b1;
    logic exp_valid = 1'b0;
    logic exp_oe = 1'b0;
    logic in_txn = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  exp_regs [256];
    logic [7:0]  exp_sub;
    logic [15:0] strobe_q [$];
    logic [7:0]  rd_got [4];

    sccb_target_if bus();

    assign bus.sio_c_i = scl;
    assign bus.sio_d_i = sda_m & ~bus.sio_d_oe;

    sccb_target #(
        .DEV_ADDR(7'h21), .SYNC_STAGES(2), .PID_VALUE(8'h76), .VER_VALUE(8'h73)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Per-cycle compare: pull-down during settled SCL-high windows, and every write pulse.
    always @(negedge clk) begin
        if (exp_valid) begin
            chk("sio_d_oe", {31'd0, bus.sio_d_oe}, {31'd0, exp_oe});
            if (in_txn) chk("busy_in_txn", {31'd0, bus.busy}, 32'd1);
        end
        if (bus.wr_strobe) begin
            if (strobe_q.size() == 0) begin
                chk("wr_strobe_unexpected", {31'd0, bus.wr_strobe}, 32'd0);
            end else begin
                logic [15:0] e;
                e = strobe_q.pop_front();
                chk("wr_addr", {24'd0, bus.wr_addr}, {24'd0, e[15:8]});
                chk("wr_data", {24'd0, bus.wr_data}, {24'd0, e[7:0]});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic ro(input logic [7:0] a);
        return a inside {8'h0A, 8'h0B, 8'h1C, 8'h1D};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) exp_regs[i] = 8'h00;
        exp_regs[8'h0A] = 8'h76;
        exp_regs[8'h0B] = 8'h73;
        exp_regs[8'h1C] = 8'h7F;
        exp_regs[8'h1D] = 8'hA2;
        exp_sub = 8'h00;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCL period: data set mid-low, settled window checked while SCL is high.
    task automatic bit_xfer(input logic drv, input logic eoe, output logic smp);
        tick(Q);
        sda_m = drv;
        tick(Q);
        scl = 1'b1;
        tick(6);
        exp_oe = eoe;
        exp_valid = 1'b1;
        tick(Q);
        smp = bus.sio_d_i;
        exp_valid = 1'b0;
        tick(2);
        scl = 1'b0;
    endtask

    task automatic start_cond();
        if (scl == 1'b0) begin
            tick(Q);
            sda_m = 1'b1;
            tick(Q);
            scl = 1'b1;
            tick(Q);
        end
        sda_m = 1'b0;
        tick(Q);
        scl = 1'b0;
    endtask

    task automatic stop_cond();
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        logic s;
        for (int i = 0; i < n; i++) bit_xfer(b[7-i], 1'b0, s);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic eack);
        logic s;
        send_bits(b, 8);
        bit_xfer(1'b1, eack, s);
        chk("ack_seen", {31'd0, ~s}, {31'd0, eack});
    endtask

    task automatic read_byte(input logic [7:0] e, input logic nack, output logic [7:0] got);
        logic s;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, ~e[7-i], s);
            got[7-i] = s;
        end
        bit_xfer(nack, 1'b0, s);
    endtask

    task automatic after_stop();
        in_txn = 1'b0;
        tick(4);
        chk("busy_after_stop", {31'd0, bus.busy}, 32'd0);
        chk("sub_addr", {24'd0, bus.sub_addr}, {24'd0, exp_sub});
    endtask

    // dev byte, then n bytes (first is the sub-address); no STOP when do_stop=0.
    task automatic do_write(input logic [7:0] dev, input int n, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2, input logic do_stop);
        logic ok;
        logic [7:0] b;
        ok = (dev[7:1] == 7'h21);
        start_cond();
        in_txn = ok;
        send_byte(dev, ok);
        for (int i = 0; i < n; i++) begin
            b = (i == 0) ? b0 : (i == 1) ? b1 : b2;
            if (ok && i > 0) begin
                if (!ro(exp_sub)) begin
                    exp_regs[exp_sub] = b;
                    strobe_q.push_back({exp_sub, b});
                end
            end
            send_byte(b, ok);
            if (ok) exp_sub = (i == 0) ? b : exp_sub + 8'd1;
        end
        if (do_stop) begin
            stop_cond();
            after_stop();
        end
    endtask

    task automatic do_read(input int n);
        logic [7:0] e, got;
        start_cond();
        in_txn = 1'b1;
        send_byte(8'h43, 1'b1);
        for (int i = 0; i < n; i++) begin
            e = exp_regs[exp_sub];
            read_byte(e, (i == n - 1), got);
            chk("rd_data", {24'd0, got}, {24'd0, e});
            rd_got[i] = got;
            if (i != n - 1) exp_sub = exp_sub + 8'd1;
        end
        stop_cond();
        after_stop();
    endtask

    initial begin
        model_reset();
        tick(6);
        reset = 1'b0;
        tick(2);
        chk("rst_oe", {31'd0, bus.sio_d_oe}, 32'd0);
        chk("rst_strobe", {31'd0, bus.wr_strobe}, 32'd0);
        chk("rst_wr_addr", {24'd0, bus.wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, bus.wr_data}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_sub_addr", {24'd0, bus.sub_addr}, 32'd0);

        // 3-phase write
        do_write(8'h42, 2, 8'h12, 8'h80, 8'h00, 1'b1);
        chk("t1_wr_addr", {24'd0, bus.wr_addr}, 32'h12);
        chk("t1_wr_data", {24'd0, bus.wr_data}, 32'h80);

        // PID read with NA
        do_write(8'h42, 1, 8'h0A, 8'h00, 8'h00, 1'b1);
        do_read(1);
        chk("t2_pid", {24'd0, rd_got[0]}, 32'h76);

        // address mismatch
        do_write(8'h60, 2, 8'h12, 8'h55, 8'h00, 1'b1);
        do_write(8'h42, 1, 8'h12, 8'h00, 8'h00, 1'b1);
        do_read(1);
        chk("t3_unchanged", {24'd0, rd_got[0]}, 32'h80);

        // burst with wrap, then read-only write
        do_write(8'h42, 3, 8'hFF, 8'hA5, 8'h5A, 1'b1);
        do_write(8'h42, 1, 8'hFF, 8'h00, 8'h00, 1'b1);
        do_read(2);
        chk("t4_ff", {24'd0, rd_got[0]}, 32'hA5);
        chk("t4_00", {24'd0, rd_got[1]}, 32'h5A);
        do_write(8'h42, 2, 8'h0B, 8'h99, 8'h00, 1'b1);
        do_write(8'h42, 1, 8'h0B, 8'h00, 8'h00, 1'b1);
        do_read(1);
        chk("t4_ver", {24'd0, rd_got[0]}, 32'h73);

        // repeated START after 4 bits of a data byte
        do_write(8'h42, 1, 8'h30, 8'h00, 8'h00, 1'b0);
        send_bits(8'hC3, 4);
        do_write(8'h42, 2, 8'h20, 8'h33, 8'h00, 1'b1);
        chk("t5_sub", {24'd0, bus.sub_addr}, 32'h21);
        do_write(8'h42, 1, 8'h20, 8'h00, 8'h00, 1'b1);
        do_read(1);
        chk("t5_reg20", {24'd0, rd_got[0]}, 32'h33);
        do_write(8'h42, 1, 8'h30, 8'h00, 8'h00, 1'b1);
        do_read(1);
        chk("t5_reg30", {24'd0, rd_got[0]}, 32'h00);

        // randomized traffic
        for (int k = 0; k < 16; k++) begin
            int op;
            logic [7:0] sa;
            logic [6:0] da;
            op = $urandom_range(0, 3);
            sa = 8'($urandom);
            if ($urandom_range(0, 3) == 0) sa = 8'h0A + 8'($urandom_range(0, 1)) + (($urandom_range(0, 1) == 1) ? 8'h12 : 8'h00);
            if (op <= 1) begin
                do_write(8'h42, $urandom_range(2, 3), sa, 8'($urandom), 8'($urandom), 1'b1);
            end else if (op == 2) begin
                do_write(8'h42, 1, sa, 8'h00, 8'h00, 1'b1);
                do_read($urandom_range(1, 2));
            end else begin
                da = 7'($urandom);
                if (da == 7'h21) da = 7'h22;
                do_write({da, 1'b0}, 2, sa, 8'($urandom), 8'h00, 1'b1);
            end
        end

        // reset while the target drives a 0 read bit (0x76 bit7 = 0)
        do_write(8'h42, 1, 8'h0A, 8'h00, 8'h00, 1'b1);
        start_cond();
        in_txn = 1'b1;
        send_byte(8'h43, 1'b1);
        tick(Q);
        chk("pre_rst_oe", {31'd0, bus.sio_d_oe}, 32'd1);
        reset = 1'b1;
        tick(1);
        chk("post_rst_oe", {31'd0, bus.sio_d_oe}, 32'd0);
        reset = 1'b0;
        model_reset();
        in_txn = 1'b0;
        chk("post_rst_sub", {24'd0, bus.sub_addr}, 32'd0);
        chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        stop_cond();
        after_stop();
        do_write(8'h42, 1, 8'h12, 8'h00, 8'h00, 1'b1);
        do_read(1);
        chk("rst_reg12", {24'd0, rd_got[0]}, 32'h00);
        do_write(8'h42, 1, 8'h1C, 8'h00, 8'h00, 1'b1);
        do_read(2);
        chk("rst_reg1c", {24'd0, rd_got[0]}, 32'h7F);
        chk("rst_reg1d", {24'd0, rd_got[1]}, 32'hA2);

        tick(4);
        chk("strobes_pending", strobe_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
